// File: rtl/capture_pkg.sv
// Shared types and geometry defaults for the camera frame-capture path.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_VS   = 2'd1,
    CAPTURE   = 2'd2,
    SWAP_WAIT = 2'd3
  } capture_state_e;

  localparam int DEF_WIDTH    = 176;
  localparam int DEF_HEIGHT   = 144;
  localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;
  localparam int BANK0_BASE   = 0;
  localparam int BANK1_BASE   = FRAME_PIXELS;

  // Bank 1 starts right after one full frame of bank 0.
  function automatic int bank_base(input logic bank, input int frame_pixels);
    if (bank) begin
      return frame_pixels;
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Pixel-stream, sync and frame-buffer write signals of the capture sequencer.
interface capture_sequencer_if #(parameter int ADDR_W = 16);
  logic              arm;
  logic              continuous;
  logic              cam_vsync;
  logic              cam_href;
  logic              pix_valid;
  logic [7:0]        pix_in;
  logic              vga_vsync_neg;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              wr_bank;
  logic              rd_bank;
  logic              busy;
  logic              frame_done;
  logic              error;

  modport master (
    output arm, continuous, cam_vsync, cam_href, pix_valid, pix_in, vga_vsync_neg,
    input  w_en, w_addr, w_data, wr_bank, rd_bank, busy, frame_done, error
  );

  modport slave (
    input  arm, continuous, cam_vsync, cam_href, pix_valid, pix_in, vga_vsync_neg,
    output w_en, w_addr, w_data, wr_bank, rd_bank, busy, frame_done, error
  );
endinterface

// File: rtl/capture_sequencer_edge_det.sv
// Registered copy of a level with combinational rise/fall pulses against that copy.
module edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic level_r,
  output logic rise,
  output logic fall
);

  // One-cycle history; reset value chosen so no edge fires out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= RESET_VAL;
    end else begin
      level_r <= level;
    end
  end

  assign rise = level & ~level_r;
  assign fall = ~level & level_r;

endmodule

// File: rtl/capture_sequencer.sv
// Frame-capture controller: writes validated camera frames into a double-buffered
// frame store and swaps banks only on VGA vertical sync.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  capture_sequencer_if.slave   bus
);

  localparam int X_W = $clog2(WIDTH + 1);
  localparam int Y_W = $clog2(HEIGHT + 1);
  localparam logic [X_W-1:0]    WIDTH_X  = X_W'(WIDTH);
  localparam logic [Y_W-1:0]    HEIGHT_Y = Y_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

  localparam logic [1:0] ST_IDLE      = 2'(IDLE);
  localparam logic [1:0] ST_WAIT_VS   = 2'(WAIT_VS);
  localparam logic [1:0] ST_CAPTURE   = 2'(CAPTURE);
  localparam logic [1:0] ST_SWAP_WAIT = 2'(SWAP_WAIT);

  logic [1:0]        state_r, state_s;
  logic [X_W-1:0]    x_r, x_inc_s;
  logic [Y_W-1:0]    y_r, y_next_s;
  logic [ADDR_W-1:0] line_base_r;
  logic              frame_bad_r, bad_s;
  logic              swap_armed_r;
  logic              wr_bank_r, rd_bank_r, busy_r, frame_done_r, error_r;
  logic              w_en_r;
  logic [ADDR_W-1:0] w_addr_r;
  logic [7:0]        w_data_r;

  logic vs_q_s, vs_rise_s, vs_fall_s;
  logic href_q_s, href_rise_s, href_fall_s;
  logic vga_q_s, vga_rise_s, vga_fall_s;
  logic unused_edges_s;
  logic in_cap_s, accept_s, line_end_s, frame_end_s;
  logic enter_cap_s, commit_s, error_set_s;

  edge_det #(.RESET_VAL(1'b1)) u_vs (
    .clk(clk), .rst_n(rst_n), .level(bus.cam_vsync),
    .level_r(vs_q_s), .rise(vs_rise_s), .fall(vs_fall_s)
  );
  edge_det #(.RESET_VAL(1'b0)) u_href (
    .clk(clk), .rst_n(rst_n), .level(bus.cam_href),
    .level_r(href_q_s), .rise(href_rise_s), .fall(href_fall_s)
  );
  edge_det #(.RESET_VAL(1'b1)) u_vga (
    .clk(clk), .rst_n(rst_n), .level(bus.vga_vsync_neg),
    .level_r(vga_q_s), .rise(vga_rise_s), .fall(vga_fall_s)
  );

  assign unused_edges_s = vs_q_s ^ href_rise_s ^ vga_q_s ^ vga_rise_s;

  // Pixel acceptance and line bookkeeping; a pixel on the HREF falling edge still
  // belongs to the line that is ending (href_q is still high).
  always_comb begin
    in_cap_s    = (state_r == ST_CAPTURE);
    accept_s    = in_cap_s & bus.pix_valid & (bus.cam_href | href_q_s)
                  & (x_r < WIDTH_X) & (y_r < HEIGHT_Y);
    line_end_s  = in_cap_s & href_fall_s;
    frame_end_s = in_cap_s & vs_rise_s;
    if (accept_s) begin
      x_inc_s = x_r + {{(X_W-1){1'b0}}, 1'b1};
    end else begin
      x_inc_s = x_r;
    end
    if (line_end_s && (y_r < HEIGHT_Y)) begin
      y_next_s = y_r + {{(Y_W-1){1'b0}}, 1'b1};
    end else begin
      y_next_s = y_r;
    end
    bad_s = frame_bad_r
            | (in_cap_s & bus.pix_valid & ~accept_s)
            | (line_end_s & (x_inc_s != WIDTH_X));
  end

  // Next-state logic.
  always_comb begin
    state_s     = state_r;
    enter_cap_s = 1'b0;
    commit_s    = 1'b0;
    error_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.arm || bus.continuous) begin
          state_s = ST_WAIT_VS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_VS: begin
        if (vs_fall_s) begin
          state_s     = ST_CAPTURE;
          enter_cap_s = 1'b1;
        end else begin
          state_s = ST_WAIT_VS;
        end
      end
      ST_CAPTURE: begin
        if (!frame_end_s) begin
          state_s = ST_CAPTURE;
        end else if ((y_next_s == HEIGHT_Y) && !bad_s) begin
          state_s = ST_SWAP_WAIT;
        end else begin
          error_set_s = 1'b1;
          state_s     = bus.continuous ? ST_WAIT_VS : ST_IDLE;
        end
      end
      ST_SWAP_WAIT: begin
        if (vga_fall_s && swap_armed_r) begin
          commit_s = 1'b1;
          state_s  = bus.continuous ? ST_WAIT_VS : ST_IDLE;
        end else begin
          state_s = ST_SWAP_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, bank and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      swap_armed_r <= 1'b0;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b1;
      frame_done_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != ST_IDLE);
      // Masks a VGA edge in the first SWAP_WAIT cycle.
      swap_armed_r <= (state_r == ST_SWAP_WAIT);
      frame_done_r <= commit_s;
      if (commit_s) begin
        wr_bank_r <= ~wr_bank_r;
        rd_bank_r <= wr_bank_r;
      end else begin
        wr_bank_r <= wr_bank_r;
        rd_bank_r <= rd_bank_r;
      end
      if (error_set_s) begin
        error_r <= 1'b1;
      end else if (bus.arm) begin
        error_r <= 1'b0;
      end else begin
        error_r <= error_r;
      end
    end
  end

  // Geometry counters; x and y stop at WIDTH/HEIGHT so addresses stay in-bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= {X_W{1'b0}};
      y_r         <= {Y_W{1'b0}};
      line_base_r <= {ADDR_W{1'b0}};
      frame_bad_r <= 1'b0;
    end else if (enter_cap_s) begin
      x_r         <= {X_W{1'b0}};
      y_r         <= {Y_W{1'b0}};
      line_base_r <= ADDR_W'(bank_base(wr_bank_r, WIDTH * HEIGHT));
      frame_bad_r <= 1'b0;
    end else if (in_cap_s) begin
      x_r         <= line_end_s ? {X_W{1'b0}} : x_inc_s;
      y_r         <= y_next_s;
      line_base_r <= (line_end_s && (y_r < HEIGHT_Y)) ? (line_base_r + WIDTH_A) : line_base_r;
      frame_bad_r <= bad_s;
    end else begin
      x_r         <= x_r;
      y_r         <= y_r;
      line_base_r <= line_base_r;
      frame_bad_r <= frame_bad_r;
    end
  end

  // Buffer write port, registered as one unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_r   <= 1'b0;
      w_addr_r <= {ADDR_W{1'b0}};
      w_data_r <= 8'd0;
    end else if (accept_s) begin
      w_en_r   <= 1'b1;
      w_addr_r <= line_base_r + ADDR_W'(x_r);
      w_data_r <= bus.pix_in;
    end else begin
      w_en_r   <= 1'b0;
      w_addr_r <= w_addr_r;
      w_data_r <= w_data_r;
    end
  end

  assign bus.w_en       = w_en_r;
  assign bus.w_addr     = w_addr_r;
  assign bus.w_data     = w_data_r;
  assign bus.wr_bank    = wr_bank_r;
  assign bus.rd_bank    = rd_bank_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.error      = error_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer on a reduced 16x12 geometry.
module tb_capture_sequencer;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int AW = 9;
  localparam int FP = W * H;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_sequencer_if #(.ADDR_W(AW)) bus();

  capture_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  fd_count = 0;
  int  wr_count = 0;
  int  max_addr = 0;
  int  first_addr = -1;

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_done === 1'b1) fd_count++;
      if (bus.w_en === 1'b1) begin
        wr_t e;
        if (wr_count == 0) first_addr = int'(bus.w_addr);
        wr_count++;
        if (int'(bus.w_addr) > max_addr) max_addr = int'(bus.w_addr);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL write_unexpected: got addr %0d data %0h, expected no write", bus.w_addr, bus.w_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.w_addr !== e.addr || bus.w_data !== e.data) begin
            n_errors++;
            $display("FAIL write: got addr %0d data %0h, expected addr %0d data %0h",
                     bus.w_addr, bus.w_data, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arm = 1'b0; bus.continuous = 1'b0; bus.cam_vsync = 1'b1; bus.cam_href = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_in = 8'd0; bus.vga_vsync_neg = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    exp_q.delete();
    fd_count = 0; wr_count = 0; max_addr = 0; first_addr = -1;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick(1);
    bus.arm = 1'b0;
  endtask

  task automatic send_line(input int y, input int npix, input int base);
    wr_t e;
    bus.cam_href = 1'b1;
    for (int i = 0; i < npix; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in = 8'(i * 13 + y * 7 + base);
      if (i < W && y < H) begin
        e.addr = AW'(base + y * W + i);
        e.data = bus.pix_in;
        exp_q.push_back(e);
      end
      tick(1);
    end
    bus.pix_valid = 1'b0;
    bus.cam_href = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input int base, input int short_line, input int long_line, input int drop_line);
    bus.cam_vsync = 1'b0;
    tick(2);
    for (int y = 0; y < H; y++) begin
      if (y == drop_line) bus.continuous = 1'b0;
      if (y == short_line) send_line(y, W - 1, base);
      else if (y == long_line) send_line(y, W + 1, base);
      else send_line(y, W, base);
    end
    bus.cam_vsync = 1'b1;
    tick(3);
  endtask

  task automatic vga_pulse();
    bus.vga_vsync_neg = 1'b0;
    tick(3);
    bus.vga_vsync_neg = 1'b1;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_before;
    idle_inputs();

    // Single armed legal frame.
    do_reset();
    check("rst_w_en", bus.w_en, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_w_data", bus.w_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_bank", bus.wr_bank, 0);
    check("rst_rd_bank", bus.rd_bank, 1);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_error", bus.error, 0);
    pulse_arm();
    check("t1_busy_wait_vs", bus.busy, 1);
    send_frame(0, -1, -1, -1);
    check("t1_busy_swap_wait", bus.busy, 1);
    check("t1_fd_before_vga", fd_count, 0);
    vga_pulse();
    check("t1_fd_count", fd_count, 1);
    check("t1_wr_bank", bus.wr_bank, 1);
    check("t1_rd_bank", bus.rd_bank, 0);
    check("t1_busy_idle", bus.busy, 0);
    check("t1_writes", wr_count, FP);
    check("t1_queue_empty", exp_q.size(), 0);

    // Continuous, dropped during the second frame.
    do_reset();
    bus.continuous = 1'b1;
    tick(2);
    check("t2_busy", bus.busy, 1);
    send_frame(0, -1, -1, -1);
    vga_pulse();
    check("t2_wr_bank_1", bus.wr_bank, 1);
    send_frame(FP, -1, -1, 6);
    check("t2_busy_swap_wait", bus.busy, 1);
    vga_pulse();
    check("t2_fd_count", fd_count, 2);
    check("t2_wr_bank_0", bus.wr_bank, 0);
    check("t2_rd_bank_1", bus.rd_bank, 1);
    check("t2_busy_idle", bus.busy, 0);
    check("t2_max_addr", max_addr, 2 * FP - 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Short line 3 -> error, no swap; ARM clears error.
    do_reset();
    pulse_arm();
    send_frame(0, 3, -1, -1);
    check("t3_error", bus.error, 1);
    check("t3_busy", bus.busy, 0);
    check("t3_writes", wr_count, FP - 1);
    vga_pulse();
    check("t3_fd_count", fd_count, 0);
    check("t3_wr_bank", bus.wr_bank, 0);
    pulse_arm();
    check("t3_error_cleared", bus.error, 0);

    // Long line 5 -> 17th pixel dropped, error.
    wr_count = 0; max_addr = 0;
    send_frame(0, -1, 5, -1);
    check("t4_error", bus.error, 1);
    check("t4_writes", wr_count, FP);
    check("t4_max_addr", max_addr, FP - 1);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_fd_count", fd_count, 0);

    // Long wait in SWAP_WAIT.
    do_reset();
    pulse_arm();
    send_frame(0, -1, -1, -1);
    wr_before = wr_count;
    tick(1000);
    check("t5_busy", bus.busy, 1);
    check("t5_no_writes", wr_count, wr_before);
    check("t5_fd_none", fd_count, 0);
    bus.vga_vsync_neg = 1'b0;
    tick(1);
    check("t5_frame_done", bus.frame_done, 1);
    check("t5_wr_bank", bus.wr_bank, 1);
    bus.vga_vsync_neg = 1'b1;
    tick(2);
    check("t5_fd_count", fd_count, 1);

    // Reset in the middle of line 6, then a fresh frame.
    do_reset();
    pulse_arm();
    bus.cam_vsync = 1'b0;
    tick(2);
    for (int y = 0; y < 6; y++) send_line(y, W, 0);
    bus.cam_href = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_t e;
      bus.pix_valid = 1'b1;
      bus.pix_in = 8'(i * 13 + 6 * 7);
      e.addr = AW'(6 * W + i);
      e.data = bus.pix_in;
      exp_q.push_back(e);
      tick(1);
    end
    bus.pix_valid = 1'b0;
    tick(2);
    check("t6_busy_before", bus.busy, 1);
    check("t6_queue_empty", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_w_en", bus.w_en, 0);
    check("t6_rst_w_addr", bus.w_addr, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_rd_bank", bus.rd_bank, 1);
    do_reset();
    pulse_arm();
    send_frame(0, -1, -1, -1);
    check("t6_first_addr", first_addr, 0);
    check("t6_writes", wr_count, FP);
    vga_pulse();
    check("t6_fd_count", fd_count, 1);
    check("t6_queue_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Frame-capture controller for the camera-to-VGA path. It sits between the down-sampler's RGB332 pixel stream and the dual-port M9K frame buffer. It generates buffer write enables and addresses, validates frame geometry, and double-buffers the frame store. Bank swaps are deferred to VGA vertical sync so the display never shows a torn frame.

## Interface
- WIDTH, 176, pixels per line
- HEIGHT, 144, lines per frame
- ADDR_W, 16, buffer address width; must satisfy 2·WIDTH·HEIGHT ≤ 2^ADDR_W
- CLK  in  1  system clock (50 MHz domain); all inputs already synchronized to it
- RESET_N  in  1  asynchronous, active-low reset
- ARM  in  1  one-cycle capture request; also clears ERROR
- CONTINUOUS  in  1  level; when high, frames are captured back-to-back
- CAM_VSYNC  in  1  camera VSYNC level; high during vertical blank
- CAM_HREF  in  1  camera HREF level; high during active line
- PIX_VALID  in  1  one-cycle strobe, one completed pixel on PIX_IN
- PIX_IN  in  8  RGB332 pixel
- VGA_VSYNC_NEG  in  1  VGA vertical sync, active low
- W_EN  out  1  buffer write enable
- W_ADDR  out  ADDR_W  buffer write address
- W_DATA  out  8  buffer write data
- RD_BANK  out  1  bank the VGA reader uses; always ~WR_BANK
- BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse when a frame is committed, i.e. at the bank swap
- ERROR  out  1  sticky; geometry mismatch seen

## Operation
- Bank base is 0 for bank 0 and WIDTH·HEIGHT for bank 1. Addresses are built incrementally: line_base + x. line_base advances by WIDTH at each line end. No multiplier is used.
- State IDLE:
  - All outputs are inactive.
  - ARM=1 or CONTINUOUS=1 moves to WAIT_VS.
- State WAIT_VS:
  - Waits for a CAM_VSYNC falling edge, then moves to CAPTURE.
  - On entry to CAPTURE: x=0, y=0, line_base = base of WR_BANK, and the internal frame_bad flag is cleared.
- State CAPTURE, accepting pixels:
  - A pixel is accepted when PIX_VALID=1, CAM_HREF=1, x<WIDTH and y<HEIGHT.
  - An accepted pixel is written to line_base+x, then x increments.
  - A PIX_VALID outside those conditions is dropped and sets frame_bad.
- State CAPTURE, line end (CAM_HREF falling edge):
  - If x≠WIDTH, frame_bad is set.
  - y increments, x returns to 0, line_base += WIDTH.
- State CAPTURE, frame end (CAM_VSYNC rising edge):
  - If y==HEIGHT and frame_bad==0, move to SWAP_WAIT.
  - Otherwise set ERROR, discard the frame without swapping, and return to WAIT_VS if CONTINUOUS=1, else IDLE.
- State SWAP_WAIT:
  - On a VGA_VSYNC_NEG falling edge: toggle WR_BANK, pulse FRAME_DONE.
  - Then go to WAIT_VS if CONTINUOUS=1, else IDLE.
- Boundary rules:
  - PIX_VALID in the same cycle as a CAM_HREF falling edge: the pixel is evaluated against the current line first, then the line advances.
  - ARM while BUSY is ignored, except that it clears ERROR.
  - Dropping CONTINUOUS mid-frame: the current frame completes and commits, then the block goes to IDLE.
  - A VGA vsync falling edge in the cycle SWAP_WAIT is entered is not used; the block waits for the next one.
  - The x, y and line_base counters saturate and never wrap into the other bank.
- Reset, including mid-frame: state=IDLE, W_EN=0, W_ADDR=0, W_DATA=0, WR_BANK=0, RD_BANK=1, BUSY=0, FRAME_DONE=0, ERROR=0.
  - Edge-detect history resets to CAM_VSYNC_q=1, CAM_HREF_q=0, VGA_VSYNC_NEG_q=1, so no spurious edge fires after reset.

## Timing
- Edges are detected against a one-cycle registered copy of each input.
- W_EN, W_ADDR and W_DATA are registered together. A write appears exactly 1 cycle after its PIX_VALID cycle, and W_EN is high for exactly 1 cycle per accepted pixel.
- FRAME_DONE and the WR_BANK/RD_BANK toggle occur together, 1 cycle after the VGA_VSYNC_NEG falling edge is sampled.
- BUSY changes in the same cycle as the state register.
- ERROR sets 1 cycle after the frame-end edge and clears 1 cycle after ARM.

## Structure
- Shared package capture_pkg holds:
  - the state enum (IDLE, WAIT_VS, CAPTURE, SWAP_WAIT);
  - the default WIDTH, HEIGHT and FRAME_PIXELS = WIDTH·HEIGHT;
  - the bank base constants.
- Sub-module edge_det: a registered level with rise and fall pulse outputs and a parameterized reset value. It is instantiated three times (CAM_VSYNC, CAM_HREF, VGA_VSYNC_NEG).

## Test plan
- Reset, ARM, one legal frame (144 lines × 176 pixels), then a VGA vsync → 25344 writes with addresses 0..25343; FRAME_DONE pulses once; WR_BANK=1, RD_BANK=0; final state IDLE.
- CONTINUOUS=1 for two legal frames → the second frame is written at 25344..50687; FRAME_DONE pulses twice; WR_BANK returns to 0.
- Line 10 carries 175 pixels → ERROR=1; no bank swap and no FRAME_DONE; a following ARM clears ERROR.
- 177 pixels in one line → the 177th pixel causes no write; ERROR=1 at frame end; no write address exceeds 25343.
- Frame end with no VGA vsync for 1000 cycles → the block stays in SWAP_WAIT with BUSY=1 and no writes; the next VGA_VSYNC_NEG fall swaps the banks within 1 cycle.
- RESET_N asserted mid-line (y=50) → all outputs take their reset values immediately; a fresh ARM plus a legal frame writes from address 0 again.
